aibnd_dly_code_ctrl: RTL and testbench
======================================

# aibnd_dly_code_ctrl

Delay-code sequencer for the AIB NAND x64 delay line. It accepts a 10-bit binary delay target: bits [9:3] are coarse, bits [2:0] are fine. It walks the delay line from its current code to the target one LSB per update, so the delay never jumps by more than one step. For every step it drives the Gray-coded `f_gray[6:0]`/`i_gray[2:0]` buses and a stretched `code_valid` level that the line's internal synchroniser can safely capture.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles the new Gray code is stable before `code_valid` rises (≥1)
- `VALID_CYC`, 4: cycles `code_valid` is held high (≥2, covers the line-side synchroniser)
- `SETTLE_CYC`, 4: cycles `code_valid` is low after each step, before the next step (≥1)

Ports:
- `ck`  in  1: controller clock
- `nrst`  in  1: reset, synchronous, active-low
- `req_vld`  in  1: new target request
- `req_code`  in  10: binary target, [9:3] coarse, [2:0] fine
- `req_jump`  in  1: load the target in one update (honoured only with the macro)
- `req_ready`  out  1: controller idle, request may be accepted
- `f_gray`  out  7: coarse Gray code to the delay line
- `i_gray`  out  3: fine Gray code to the delay line
- `code_valid`  out  1: code-update strobe to the delay line
- `cur_code`  out  10: binary code currently driven
- `busy`  out  1: sequence in progress
- `done`  out  1: one-cycle pulse when the target is reached

## Operation
- Reset values: `cur_code` 0, `f_gray` 0, `i_gray` 0, `code_valid` 0, `busy` 0, `done` 0, `req_ready` 1, state IDLE.
- A request is accepted on a `ck` edge where `req_vld && req_ready`. `req_code` is captured into `tgt`. `req_ready` drops and `busy` rises in the next cycle.
- If `tgt == cur_code` at acceptance:
  - no step is taken and `code_valid` stays low;
  - `done` pulses in the next cycle and the FSM stays in IDLE.
- State machine:
  - IDLE: on acceptance with `tgt != cur_code`, go to STEP.
  - STEP (1 cycle): `cur_code` becomes `cur_code ± 1` toward `tgt`, registered. Gray outputs are registered from the new value. Go to SETUP.
  - SETUP (`SETUP_CYC`): `code_valid` 0, then go to VALID.
  - VALID (`VALID_CYC`): `code_valid` 1, then go to SETTLE.
  - SETTLE (`SETTLE_CYC`): `code_valid` 0. Go to STEP if `cur_code != tgt`, otherwise go to IDLE with `done` = 1 for one cycle.
- Arithmetic is unsigned 10-bit with no wrap-around. The range 0…1023 is bounded by `tgt`, so saturation never triggers.
- A fine carry or borrow (e.g. 0x07→0x08) changes both fields within one step. Both buses are registered on the same edge.
- Gray conversion is per field: g = b ^ (b>>1), applied separately to coarse[6:0] and fine[2:0].
- `req_vld` while busy is ignored and not queued. `req_code` is sampled only at acceptance.
- Gray outputs never change while `code_valid` is 1, nor during SETUP.
- `nrst` low mid-sequence returns every output to its reset value on the next edge. The following request steps from 0.

## Timing
- Per step: 1 + `SETUP_CYC` + `VALID_CYC` + `SETTLE_CYC` cycles (11 at defaults).
- N steps: `done` is high in cycle N×11 + 1 after the accepting edge (cycle 0). `req_ready` returns in that same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `code_valid` rises exactly `SETUP_CYC` cycles after the Gray edge. It is a level, not a pulse.

## Configuration
- `AIBND_DLY_CTRL_JUMP_EN` defined: `req_jump`=1 at acceptance performs a single STEP that loads `tgt` directly, followed by one SETUP/VALID/SETTLE sequence and then `done`.
- Undefined: `req_jump` is ignored and all requests step by one LSB. The port remains present.

## Structure
- Package `aibnd_dly_ctrl_pkg` holds:
  - state enum IDLE/STEP/SETUP/VALID/SETTLE;
  - constants COARSE_W=7, FINE_W=3, CODE_W=10;
  - phase-counter width derived from the maximum of the three cycle parameters.
- One sub-module: `aibnd_bin2gray`, parameterised width, combinational, instantiated once for each field ahead of the output registers.

## Test plan
- Reset then idle: all outputs at reset values, `req_ready`=1, `code_valid` never toggles.
- Request 0x003 from 0:
  - three `code_valid` high windows of 4 cycles each;
  - `i_gray` sequence 001, 011, 010;
  - `done` in cycle 34.
- Request 0x008 from 0x007: `f_gray` 0→1 and `i_gray` 100→000 on the same edge, one `code_valid` window, `done` in cycle 12.
- Request equal to `cur_code`: no `code_valid`, `done` in cycle 1. A `req_vld` pulse during a busy sequence is not accepted and `tgt` is unchanged.
- Reset mid-sequence: `nrst` low during VALID clears `code_valid`, `cur_code` and both Gray buses to 0 on the next edge.
- With `AIBND_DLY_CTRL_JUMP_EN`: `req_jump`=1 with target 0x3FF from 0 gives a single update, `f_gray`=1000000, `i_gray`=100, `done` in cycle 12.

Source files
------------

// File: rtl/aibnd_dly_code_ctrl_pkg.sv
// Shared types and widths for the AIB NAND x64 delay-code sequencer.
// The phase counter is sized by the longest of the three timing phases.
package aibnd_dly_ctrl_pkg;

    localparam int unsigned COARSE_W = 7;
    localparam int unsigned FINE_W   = 3;
    localparam int unsigned CODE_W   = 10;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETUP,
        VALID,
        SETTLE
    } state_t;

    function automatic int unsigned phase_cnt_w(input int unsigned setup_cyc,
                                                input int unsigned valid_cyc,
                                                input int unsigned settle_cyc);
        int unsigned max_cyc;
        int unsigned w;
        max_cyc = setup_cyc;
        if (valid_cyc  > max_cyc) max_cyc = valid_cyc;
        if (settle_cyc > max_cyc) max_cyc = settle_cyc;
        w = $clog2(max_cyc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/aibnd_dly_code_ctrl_if.sv
// Request handshake and delay-line code bus of the delay-code sequencer.
// master = requester side, slave = the sequencer itself.
interface aibnd_dly_code_ctrl_if;
    import aibnd_dly_ctrl_pkg::*;

    logic                req_vld;
    logic [CODE_W-1:0]   req_code;
    logic                req_jump;
    logic                req_ready;
    logic [COARSE_W-1:0] f_gray;
    logic [FINE_W-1:0]   i_gray;
    logic                code_valid;
    logic [CODE_W-1:0]   cur_code;
    logic                busy;
    logic                done;

    modport master (
        output req_vld, req_code, req_jump,
        input  req_ready, f_gray, i_gray, code_valid, cur_code, busy, done
    );

    modport slave (
        input  req_vld, req_code, req_jump,
        output req_ready, f_gray, i_gray, code_valid, cur_code, busy, done
    );

endinterface

// File: rtl/aibnd_dly_code_ctrl_bin2gray.sv
// Combinational binary-to-Gray converter, one instance per code field.
module aibnd_bin2gray #(
    parameter int unsigned W = 7
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/aibnd_dly_code_ctrl.sv
// Delay-code sequencer: walks the delay line one LSB per update toward the target.
// Optional macro AIBND_DLY_CTRL_JUMP_EN enables single-update jumps via req_jump.
module aibnd_dly_code_ctrl
    import aibnd_dly_ctrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned VALID_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                 ck,
    input  logic                 nrst,
    aibnd_dly_code_ctrl_if.slave bus
);

    localparam int unsigned PH_W = phase_cnt_w(SETUP_CYC, VALID_CYC, SETTLE_CYC);
    localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] VALID_LAST  = PH_W'(VALID_CYC - 1);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);

    state_t              state;
    logic [PH_W-1:0]     ph_cnt;
    logic [CODE_W-1:0]   tgt;
    logic                jump_q;
    logic                jump_req;
    logic [CODE_W-1:0]   next_code;
    logic [COARSE_W-1:0] f_gray_nxt;
    logic [FINE_W-1:0]   i_gray_nxt;

`ifdef AIBND_DLY_CTRL_JUMP_EN
    assign jump_req = bus.req_jump;
`else
    logic unused_jump;
    assign jump_req    = 1'b0;
    assign unused_jump = bus.req_jump;
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_code = bus.cur_code;
        if (jump_q)
            next_code = tgt;
        else if (tgt > bus.cur_code)
            next_code = bus.cur_code + 1'b1;
        else if (tgt < bus.cur_code)
            next_code = bus.cur_code - 1'b1;
    end

    // Gray conversion sits ahead of the output registers so both fields move on one edge.
    aibnd_bin2gray #(.W(COARSE_W)) u_coarse_gray (
        .bin  (next_code[CODE_W-1:FINE_W]),
        .gray (f_gray_nxt)
    );

    aibnd_bin2gray #(.W(FINE_W)) u_fine_gray (
        .bin  (next_code[FINE_W-1:0]),
        .gray (i_gray_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ck) begin
        if (!nrst) begin
            state          <= IDLE;
            ph_cnt         <= '0;
            tgt            <= '0;
            jump_q         <= 1'b0;
            bus.cur_code   <= '0;
            bus.f_gray     <= '0;
            bus.i_gray     <= '0;
            bus.code_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.req_ready  <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_vld && bus.req_ready) begin
                        tgt    <= bus.req_code;
                        jump_q <= jump_req;
                        if (bus.req_code == bus.cur_code) begin
                            bus.done <= 1'b1;
                        end else begin
                            state         <= STEP;
                            bus.busy      <= 1'b1;
                            bus.req_ready <= 1'b0;
                        end
                    end
                end
                STEP: begin
                    bus.cur_code <= next_code;
                    bus.f_gray   <= f_gray_nxt;
                    bus.i_gray   <= i_gray_nxt;
                    ph_cnt       <= '0;
                    state        <= SETUP;
                end
                SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        ph_cnt         <= '0;
                        bus.code_valid <= 1'b1;
                        state          <= VALID;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                VALID: begin
                    if (ph_cnt == VALID_LAST) begin
                        ph_cnt         <= '0;
                        bus.code_valid <= 1'b0;
                        state          <= SETTLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (ph_cnt == SETTLE_LAST) begin
                        ph_cnt <= '0;
                        if (bus.cur_code != tgt) begin
                            state <= STEP;
                        end else begin
                            state         <= IDLE;
                            jump_q        <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            bus.req_ready <= 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aibnd_dly_code_ctrl.sv
// Self-checking bench for aibnd_dly_code_ctrl: directed table, hand sequences, random walk.
// Cycle c of a request is the window sampled at the c-th falling edge after the accepting edge.
module tb_aibnd_dly_code_ctrl;
    import aibnd_dly_ctrl_pkg::*;

    localparam int S_CYC  = 2;
    localparam int V_CYC  = 4;
    localparam int T_CYC  = 4;
    localparam int STEP_T = 1 + S_CYC + V_CYC + T_CYC;

    logic ck;
    logic nrst;
    aibnd_dly_code_ctrl_if bus();

    aibnd_dly_code_ctrl #(
        .SETUP_CYC  (S_CYC),
        .VALID_CYC  (V_CYC),
        .SETTLE_CYC (T_CYC)
    ) dut (
        .ck   (ck),
        .nrst (nrst),
        .bus  (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_vec = 0;
    int n_err = 0;
    int model_cur = 0;

    typedef struct {
        logic [9:0] code;
        logic       jump;
        int         exp_windows;
        int         exp_done_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] gray7(input int b);
        logic [6:0] c;
        c = 7'(b >> 3);
        return c ^ (c >> 1);
    endfunction

    function automatic logic [2:0] gray3(input int b);
        logic [2:0] f;
        f = 3'(b);
        return f ^ (f >> 1);
    endfunction

    task automatic check_idle_outputs(input string tag, input int code);
        check({tag, "_cur"},   bus.cur_code,   code);
        check({tag, "_fgray"}, bus.f_gray,     gray7(code));
        check({tag, "_igray"}, bus.i_gray,     gray3(code));
        check({tag, "_cv"},    bus.code_valid, 0);
        check({tag, "_busy"},  bus.busy,       0);
        check({tag, "_done"},  bus.done,       0);
        check({tag, "_ready"}, bus.req_ready,  1);
    endtask

    // Issues one request and compares every output each cycle against the step-walk model.
    task automatic run_req(input logic [9:0] code, input logic jump, input int inject,
                           output int windows, output int done_cyc);
        int seq[$];
        int steps, start, k, n, s, ph;
        int e_cur;
        logic e_cv, e_done, e_busy, prev_cv;
        start = model_cur;
        if (int'(code) != start) begin
`ifdef AIBND_DLY_CTRL_JUMP_EN
            if (jump) seq.push_back(int'(code));
            else
`endif
            for (int v = start; v != int'(code); ) begin
                v = (int'(code) > v) ? v + 1 : v - 1;
                seq.push_back(v);
            end
        end
        steps = seq.size();
        @(negedge ck);
        bus.req_vld  = 1'b1;
        bus.req_code = code;
        bus.req_jump = jump;
        windows  = 0;
        done_cyc = 0;
        prev_cv  = 1'b0;
        for (int c = 1; c <= STEP_T * steps + 2; c++) begin
            @(negedge ck);
            if (c == 1) begin
                bus.req_vld  = 1'b0;
                bus.req_code = 10'($urandom);
                bus.req_jump = 1'($urandom);
            end
            if (inject > 0 && c == inject) begin
                bus.req_vld  = 1'b1;
                bus.req_code = 10'($urandom);
            end
            if (inject > 0 && c == inject + 1) bus.req_vld = 1'b0;
            k = c - 1;
            if (steps == 0) begin
                e_cur = start;
                e_cv  = 1'b0;
                e_busy = 1'b0;
            end else begin
                n = 0;
                if (k >= 1) n = ((k - 1) / STEP_T + 1 < steps) ? (k - 1) / STEP_T + 1 : steps;
                e_cur = (n == 0) ? start : seq[n-1];
                s  = (k >= 1) ? (k - 1) / STEP_T : steps;
                ph = (k >= 1) ? (k - 1) % STEP_T : 0;
                e_cv = (s < steps) && (ph >= S_CYC) && (ph < S_CYC + V_CYC);
                e_busy = (c <= STEP_T * steps);
            end
            e_done = (c == STEP_T * steps + 1);
            check("cur_code",   bus.cur_code,   e_cur);
            check("f_gray",     bus.f_gray,     gray7(e_cur));
            check("i_gray",     bus.i_gray,     gray3(e_cur));
            check("code_valid", bus.code_valid, e_cv);
            check("done",       bus.done,       e_done);
            check("busy",       bus.busy,       e_busy);
            check("req_ready",  bus.req_ready,  !e_busy);
            if (bus.code_valid && !prev_cv) windows++;
            if (bus.done && done_cyc == 0) done_cyc = c;
            prev_cv = bus.code_valid;
        end
        model_cur = int'(code);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, d, t;
        bus.req_vld  = 1'b0;
        bus.req_code = '0;
        bus.req_jump = 1'b0;
        nrst = 1'b0;
        repeat (3) @(negedge ck);
        check_idle_outputs("reset", 0);
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge ck);
            check_idle_outputs("idle", 0);
        end

        vecs.push_back('{10'h003, 1'b0, 3, 34});
        vecs.push_back('{10'h007, 1'b0, 4, 45});
        vecs.push_back('{10'h008, 1'b0, 1, 12});
        vecs.push_back('{10'h008, 1'b0, 0, 1});
`ifdef AIBND_DLY_CTRL_JUMP_EN
        vecs.push_back('{10'h006, 1'b1, 1, 12});
        vecs.push_back('{10'h000, 1'b0, 6, 67});
        vecs.push_back('{10'h3FF, 1'b1, 1, 12});
        vecs.push_back('{10'h000, 1'b1, 1, 12});
`else
        vecs.push_back('{10'h006, 1'b1, 2, 23});
        vecs.push_back('{10'h000, 1'b0, 6, 67});
`endif
        foreach (vecs[i]) begin
            run_req(vecs[i].code, vecs[i].jump, (i == 1) ? 5 : 0, w, d);
            check($sformatf("vec%0d_windows", i), w, vecs[i].exp_windows);
            check($sformatf("vec%0d_done_cyc", i), d, vecs[i].exp_done_cyc);
        end

        // Reset while code_valid is high clears everything on the next edge.
        @(negedge ck);
        bus.req_vld  = 1'b1;
        bus.req_code = 10'h010;
        @(negedge ck);
        bus.req_vld = 1'b0;
        for (int i = 0; i < 40 && !bus.code_valid; i++) @(negedge ck);
        check("mid_valid_reached", bus.code_valid, 1);
        nrst = 1'b0;
        @(negedge ck);
        check_idle_outputs("mid_reset", 0);
        nrst = 1'b1;
        model_cur = 0;
        run_req(10'h002, 1'b0, 0, w, d);
        check("post_reset_windows", w, 2);
        check("post_reset_done_cyc", d, 23);

        for (int r = 0; r < 20; r++) begin
            t = model_cur + int'($urandom_range(0, 24)) - 12;
            if (t < 0) t = 0;
            if (t > 1023) t = 1023;
            run_req(10'(t), 1'($urandom), ($urandom_range(0, 1) == 1) ? 5 : 0, w, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
